// File: rtl/riscv_pkg.sv
// Shared core definitions: default register file geometry and the
// register file sequencer state encoding.
package riscv_pkg;

    localparam int XLEN_DEFAULT  = 32;
    localparam int NREGS_DEFAULT = 32;
    localparam int AW_DEFAULT    = $clog2(NREGS_DEFAULT);

    typedef logic [AW_DEFAULT-1:0] reg_addr_t;

    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_RUN   = 1'b1
    } rf_state_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write bit per register: set by decode, cleared by writeback,
// with a new producer (set) taking priority over a retiring one (clear).
module rf_scoreboard
    import riscv_pkg::*;
#(
    parameter int NREGS = NREGS_DEFAULT,
    parameter int NRD   = 2,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              set_en,
    input  logic [AW-1:0]     set_addr,
    input  logic              clr_en,
    input  logic [AW-1:0]     clr_addr,
    input  logic [NRD*AW-1:0] look_addr,
    output logic [NRD-1:0]    look_pend
);

    logic [NREGS-1:0] sb;
    logic [NREGS-1:0] sb_next;

    always_comb begin
        sb_next = sb;
        if (clr_en) begin
            sb_next[clr_addr] = 1'b0;
        end
        if (set_en) begin
            sb_next[set_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sb <= '0;
        end else begin
            sb <= sb_next;
        end
    end

    always_comb begin
        look_pend = '0;
        for (int i = 0; i < NRD; i++) begin
            look_pend[i] = sb[look_addr[i*AW +: AW]];
        end
    end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with write bypass, a reset-time clearing
// sequencer and a per-register pending-write scoreboard.
module reg_file_mp
    import riscv_pkg::*;
#(
    parameter int XLEN     = XLEN_DEFAULT,
    parameter int NREGS    = NREGS_DEFAULT,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    output logic                init_busy,
    input  logic [NRD*AW-1:0]   rs_addr,
    output logic [NRD*XLEN-1:0] rs_data,
    output logic [NRD-1:0]      rs_pending,
    input  logic                RegWrite,
    input  logic [AW-1:0]       rd_addr,
    input  logic [XLEN-1:0]     rd_data,
    input  logic                sb_set,
    input  logic [AW-1:0]       sb_addr
);

    localparam logic [AW:0] LAST_IDX = (AW+1)'(NREGS - 1);

    rf_state_e        state;
    rf_state_e        state_next;
    logic [AW:0]      cnt;
    logic [AW:0]      cnt_next;
    logic             clr_we;
    logic             run;
    logic             wr_run;
    logic             wr_keep;
    logic             set_keep;
    logic [NRD-1:0]   sb_pend;
    logic [XLEN-1:0]  regs [NREGS];

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        clr_we     = 1'b0;
        case (state)
            RF_CLEAR: begin
                clr_we   = 1'b1;
                cnt_next = cnt + (AW+1)'(1);
                if (cnt == LAST_IDX) begin
                    state_next = RF_RUN;
                end
            end
            RF_RUN: begin
                state_next = RF_RUN;
            end
            default: begin
                state_next = RF_CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RF_CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    assign run       = (state == RF_RUN);
    assign init_busy = ~run;
    assign wr_run    = RegWrite && run;
    assign wr_keep   = wr_run && !((ZERO_REG != 0) && (rd_addr == '0));
    assign set_keep  = sb_set && run && !((ZERO_REG != 0) && (sb_addr == '0));

    // Storage has no reset; the sequencer zeroes it one entry per cycle.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            regs[cnt[AW-1:0]] <= '0;
        end else if (wr_keep) begin
            regs[rd_addr] <= rd_data;
        end
    end

    rf_scoreboard #(
        .NREGS (NREGS),
        .NRD   (NRD),
        .AW    (AW)
    ) u_sb (
        .clk       (clk),
        .rst       (rst),
        .set_en    (set_keep),
        .set_addr  (sb_addr),
        .clr_en    (wr_keep),
        .clr_addr  (rd_addr),
        .look_addr (rs_addr),
        .look_pend (sb_pend)
    );

    for (genvar i = 0; i < NRD; i++) begin : g_port
        logic [AW-1:0] addr;
        logic          is_zero;
        logic          hit;

        assign addr    = rs_addr[i*AW +: AW];
        assign is_zero = (ZERO_REG != 0) && (addr == '0);
        assign hit     = (BYPASS != 0) && wr_run && (rd_addr == addr);

        assign rs_data[i*XLEN +: XLEN] = (!run || is_zero) ? '0 :
                                         hit               ? rd_data :
                                                             regs[addr];
        // A producer writing back this cycle is no longer outstanding.
        assign rs_pending[i] = run && !is_zero && !hit && sb_pend[i];
    end

endmodule
